// File: rtl/btn_event_decoder_if.sv
// Signal bundle between a debounced button level and the gesture events decoded from it.
interface btn_event_decoder_if;
    logic btn_level;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output btn_level,
        input  press_pulse,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  btn_level,
        output press_pulse,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output held
    );
endinterface

// File: rtl/btn_event_decoder.sv
// Turns a clean button level into one-cycle press / short / long / repeat events plus a held level.
module btn_event_decoder #(
    parameter int CLKS_PER_MS   = 100_000,
    parameter int LONG_PRESS_MS = 500,
    parameter int REPEAT_MS     = 100,
    parameter int REPEAT_EN     = 1
) (
    input  logic               clk,
    input  logic               reset,
    btn_event_decoder_if.slave bus
);
    localparam int L_CYC   = LONG_PRESS_MS * CLKS_PER_MS;
    localparam int R_CYC   = REPEAT_MS * CLKS_PER_MS;
    localparam int MAX_CYC = (L_CYC > R_CYC) ? L_CYC : R_CYC;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] L_TERM = CNT_W'(L_CYC - 1);
    localparam logic [CNT_W-1:0] R_TERM = CNT_W'(R_CYC - 1);

    typedef enum logic [1:0] {
        ST_LOCKOUT = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_HELD    = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             press_reg, press_next;
    logic             short_reg, short_next;
    logic             long_reg, long_next;
    logic             repeat_reg, repeat_next;
    logic             held_reg, held_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_LOCKOUT;
            cnt_reg    <= '0;
            press_reg  <= 1'b0;
            short_reg  <= 1'b0;
            long_reg   <= 1'b0;
            repeat_reg <= 1'b0;
            held_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            press_reg  <= press_next;
            short_reg  <= short_next;
            long_reg   <= long_next;
            repeat_reg <= repeat_next;
            held_reg   <= held_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        press_next  = 1'b0;
        short_next  = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;

        case (state_reg)
            // A level still high from before reset must be released before it can count as a press.
            ST_LOCKOUT: begin
                if (!bus.btn_level) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.btn_level) begin
                    state_next = ST_PRESSED;
                    press_next = 1'b1;
                end
            end
            ST_PRESSED: begin
                // Release is tested first so it beats the long-press threshold in the same cycle.
                if (!bus.btn_level) begin
                    state_next = ST_IDLE;
                    short_next = 1'b1;
                end else if (cnt_reg == L_TERM) begin
                    state_next = ST_HELD;
                    long_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HELD: begin
                if (!bus.btn_level) begin
                    state_next = ST_IDLE;
                end else if (REPEAT_EN != 0) begin
                    if (cnt_reg == R_TERM) begin
                        cnt_next    = '0;
                        repeat_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_LOCKOUT;
            end
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
        end
        held_next = (state_next == ST_PRESSED) || (state_next == ST_HELD);
    end

    assign bus.press_pulse  = press_reg;
    assign bus.short_pulse  = short_reg;
    assign bus.long_pulse   = long_reg;
    assign bus.repeat_pulse = repeat_reg;
    assign bus.held         = held_reg;
endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench: two decoders (repeat on / off) share one random button stream checked against a timing model.
module tb_btn_event_decoder;
    localparam int CPM = 10;
    localparam int LMS = 5;
    localparam int RMS = 2;
    localparam int L   = LMS * CPM;
    localparam int R   = RMS * CPM;

    localparam logic [3:0] EV_PRESS  = 4'b1000;
    localparam logic [3:0] EV_SHORT  = 4'b0100;
    localparam logic [3:0] EV_LONG   = 4'b0010;
    localparam logic [3:0] EV_REPEAT = 4'b0001;

    typedef struct {
        int         e;
        logic [3:0] ev;
    } ev_rec_t;

    typedef struct {
        int   e;
        logic h;
    } h_rec_t;

    logic clk;
    logic reset;
    logic btn;
    int   edge_no = -1;
    bit   done;
    int   pass_cnt;
    int   total_cnt;

    ev_rec_t evq0[$];
    ev_rec_t evq1[$];
    h_rec_t  hq0[$];
    h_rec_t  hq1[$];

    bit locked[2];
    bit active[2];
    int start_e[2];
    bit rep_en[2];

    btn_event_decoder_if bus_a ();
    btn_event_decoder_if bus_b ();
    assign bus_a.btn_level = btn;
    assign bus_b.btn_level = btn;

    btn_event_decoder #(
        .CLKS_PER_MS(CPM), .LONG_PRESS_MS(LMS), .REPEAT_MS(RMS), .REPEAT_EN(1)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    btn_event_decoder #(
        .CLKS_PER_MS(CPM), .LONG_PRESS_MS(LMS), .REPEAT_MS(RMS), .REPEAT_EN(0)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, inst, edge_no, act, exp);
        end
    endtask

    // Reference: events follow from how many edges have passed since the press was sampled.
    task automatic model_step(input int e, input logic b, input logic r);
        for (int i = 0; i < 2; i++) begin
            logic [3:0] ev;
            logic       h;
            int         d;
            ev = 4'b0;
            h  = 1'b0;
            if (r) begin
                locked[i] = 1'b1;
                active[i] = 1'b0;
            end else if (locked[i]) begin
                if (!b) locked[i] = 1'b0;
            end else if (!active[i]) begin
                if (b) begin
                    active[i]  = 1'b1;
                    start_e[i] = e;
                    ev         = EV_PRESS;
                    h          = 1'b1;
                end
            end else begin
                d = e - start_e[i];
                if (!b) begin
                    active[i] = 1'b0;
                    if (d <= L) ev = EV_SHORT;
                end else begin
                    h = 1'b1;
                    if (d == L) ev = EV_LONG;
                    else if (d > L && rep_en[i] && ((d - L) % R) == 0) ev = EV_REPEAT;
                end
            end
            if (i == 0) begin
                hq0.push_back('{e, h});
                if (ev != 4'b0) evq0.push_back('{e, ev});
            end else begin
                hq1.push_back('{e, h});
                if (ev != 4'b0) evq1.push_back('{e, ev});
            end
        end
    endtask

    task automatic step(input logic b, input logic r);
        @(posedge clk);
        #1;
        btn   = b;
        reset = r;
        model_step(edge_no + 1, b, r);
    endtask

    task automatic hold(input logic b, input int n);
        for (int k = 0; k < n; k++) step(b, 1'b0);
    endtask

    task automatic mon(input int i, input logic [3:0] vec, input logic h);
        h_rec_t  hr;
        ev_rec_t er;
        bit      have_h;
        bit      have_e;
        have_h = 1'b0;
        have_e = 1'b0;
        if (i == 0) begin
            if (hq0.size() > 0 && hq0[0].e == edge_no) begin hr = hq0.pop_front(); have_h = 1'b1; end
            while (evq0.size() > 0 && evq0[0].e < edge_no) begin
                er = evq0.pop_front();
                chk("missing_event", i, 32'(vec), 32'(er.ev));
            end
            if (evq0.size() > 0 && evq0[0].e == edge_no) begin er = evq0.pop_front(); have_e = 1'b1; end
        end else begin
            if (hq1.size() > 0 && hq1[0].e == edge_no) begin hr = hq1.pop_front(); have_h = 1'b1; end
            while (evq1.size() > 0 && evq1[0].e < edge_no) begin
                er = evq1.pop_front();
                chk("missing_event", i, 32'(vec), 32'(er.ev));
            end
            if (evq1.size() > 0 && evq1[0].e == edge_no) begin er = evq1.pop_front(); have_e = 1'b1; end
        end
        if (have_h) chk("held", i, 32'(h), 32'(hr.h));
        if (have_e) chk("event", i, 32'(vec), 32'(er.ev));
        else if (vec != 4'b0) chk("unexpected_event", i, 32'(vec), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!done && edge_no >= 0) begin
            mon(0, {bus_a.press_pulse, bus_a.short_pulse, bus_a.long_pulse, bus_a.repeat_pulse}, bus_a.held);
            mon(1, {bus_b.press_pulse, bus_b.short_pulse, bus_b.long_pulse, bus_b.repeat_pulse}, bus_b.held);
        end
    end

    initial begin
        int  len;
        int  pick;
        logic lvl;
        reset     = 1'b1;
        btn       = 1'b0;
        done      = 1'b0;
        pass_cnt  = 0;
        total_cnt = 0;
        rep_en[0] = 1'b1;
        rep_en[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            locked[i]  = 1'b1;
            active[i]  = 1'b0;
            start_e[i] = 0;
        end

        repeat (3) step(1'b0, 1'b1);
        hold(1'b0, 5);
        // short press, long hold with repeats, release exactly at the threshold edge
        hold(1'b1, 10);  hold(1'b0, 5);
        hold(1'b1, 120); hold(1'b0, 5);
        hold(1'b1, L);   hold(1'b0, 5);
        hold(1'b1, L + 1); hold(1'b0, 1);
        hold(1'b1, 3);   hold(1'b0, 4);
        // button held through reset, then released and re-pressed
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        hold(1'b1, 100); hold(1'b0, 3); hold(1'b1, 5); hold(1'b0, 3);
        // reset while in the held phase
        hold(1'b1, 80);  step(1'b1, 1'b1); hold(1'b1, 30);
        hold(1'b0, 3);   hold(1'b1, 4);    hold(1'b0, 3);
        // long hold that would repeat several times
        hold(1'b1, 200); hold(1'b0, 3);

        lvl = 1'b0;
        for (int s = 0; s < 60; s++) begin
            lvl  = ~lvl;
            pick = $urandom_range(0, 9);
            if (pick == 0)      len = L;
            else if (pick == 1) len = L + 1 + R * $urandom_range(0, 2);
            else if (pick == 2) len = 1;
            else                len = $urandom_range(1, 90);
            if ($urandom_range(0, 14) == 0) step(lvl, 1'b1);
            hold(lvl, len);
        end
        hold(1'b0, 5);
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        chk("event_queue_empty", 0, 32'(evq0.size()), 32'd0);
        chk("event_queue_empty", 1, 32'(evq1.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
